// File: rtl/watch_set_fsm_pkg.sv
// Shared types for the watch time-setting sequencer: state enum, field codes
// and the MODE-button state sequence.
package watch_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_SEC  = 2'd1,
      SET_MIN  = 2'd2,
      SET_HOUR = 2'd3
   } state_t;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_SEC  = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_HOUR = 2'd3;

   // MODE walks hour -> minute -> second -> back to running
   function automatic state_t next_mode(input state_t s);
      state_t r;
      r = RUN;
      case (s)
         RUN:      r = SET_HOUR;
         SET_HOUR: r = SET_MIN;
         SET_MIN:  r = SET_SEC;
         SET_SEC:  r = RUN;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] field_of(input state_t s);
      logic [1:0] f;
      f = FIELD_NONE;
      case (s)
         RUN:      f = FIELD_NONE;
         SET_SEC:  f = FIELD_SEC;
         SET_MIN:  f = FIELD_MIN;
         SET_HOUR: f = FIELD_HOUR;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/watch_set_fsm_if.sv
// Button-in / adjust-pulse-out bundle between the debouncers, the setting
// sequencer and the watch counter datapath.
interface watch_set_fsm_if;
   logic       en;
   logic       btn_mode;
   logic       btn_inc;
   logic       tick_sec;
   logic       tick_min;
   logic       tick_hour;
   logic [1:0] field;
   logic       setting;
   logic       blink;

   modport master (
      output en, btn_mode, btn_inc,
      input  tick_sec, tick_min, tick_hour, field, setting, blink
   );

   modport slave (
      input  en, btn_mode, btn_inc,
      output tick_sec, tick_min, tick_hour, field, setting, blink
   );
endinterface

// File: rtl/watch_set_fsm_ms_tick_gen.sv
// Millisecond prescaler: one-cycle ms_tick every DIV clocks, phase restarted
// synchronously so the first tick lands exactly DIV cycles after a restart.
module ms_tick_gen #(
   parameter int DIV = 100_000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic ms_tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (restart || cnt == W'(DIV - 1))
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign ms_tick = !restart && (cnt == W'(DIV - 1));

endmodule

// File: rtl/watch_set_fsm.sv
// Time-setting sequencer: MODE/INC buttons to hour/min/sec adjust pulses with
// inactivity timeout and blink; hold-to-repeat only when WATCH_SET_AUTOREPEAT_EN is defined.
module watch_set_fsm
   import watch_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int HOLD_MS    = 500,
   parameter int REPEAT_MS  = 100,
   parameter int TIMEOUT_MS = 10_000,
   parameter int BLINK_MS   = 250
) (
   input  logic           clk,
   input  logic           reset,
   watch_set_fsm_if.slave bus
);

   localparam int DIV  = CLK_HZ / 1000;
   localparam int TO_W = $clog2(TIMEOUT_MS + 1);
   localparam int BL_W = $clog2(BLINK_MS + 1);

   state_t     state, state_next;
   logic       mode_prev, inc_prev, armed;
   logic       mode_edge, inc_edge, any_edge;
   logic       ms_tick;
   logic       inc_pulse, repeat_fire, fire, timeout_hit;
   logic [TO_W-1:0] to_cnt;
   logic [BL_W-1:0] blink_cnt;
   logic       tick_sec_q, tick_min_q, tick_hour_q, setting_q, blink_q;
   logic [1:0] field_q;

   // A button held through reset must be released before it can count as an edge
   assign mode_edge = armed && bus.btn_mode && !mode_prev;
   assign inc_edge  = armed && bus.btn_inc  && !inc_prev;
   assign any_edge  = mode_edge || inc_edge;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_prev <= 1'b0;
         inc_prev  <= 1'b0;
         armed     <= 1'b0;
      end else begin
         mode_prev <= bus.btn_mode;
         inc_prev  <= bus.btn_inc;
         armed     <= armed || (!bus.btn_mode && !bus.btn_inc);
      end
   end

   ms_tick_gen #(.DIV(DIV)) u_ms_tick (
      .clk     (clk),
      .reset   (reset),
      .restart (any_edge),
      .ms_tick (ms_tick)
   );

`ifdef WATCH_SET_AUTOREPEAT_EN
   localparam int REP_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic             rep_active, rep_first;
   logic [REP_W-1:0] rep_cnt, rep_target;

   assign rep_target = rep_first ? REP_W'(HOLD_MS - 1) : REP_W'(REPEAT_MS - 1);

   // Repeat is armed only by a fresh INC edge and dies on release, MODE or leaving the state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rep_active <= 1'b0;
         rep_first  <= 1'b0;
         rep_cnt    <= '0;
      end else if (inc_pulse) begin
         rep_active <= 1'b1;
         rep_first  <= 1'b1;
         rep_cnt    <= '0;
      end else if (!bus.en || mode_edge || !bus.btn_inc || state_next != state) begin
         rep_active <= 1'b0;
         rep_first  <= 1'b0;
         rep_cnt    <= '0;
      end else if (rep_active && ms_tick) begin
         if (rep_cnt == rep_target) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else if (rep_cnt != REP_W'(REP_MAX)) begin
            rep_cnt <= rep_cnt + 1'b1;
         end
      end
   end
`else
   localparam int repeat_cfg_unused = HOLD_MS + REPEAT_MS;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= RUN;
      else
         state <= state_next;
   end

   // Priority: en low, then MODE, then timeout; INC never changes state
   always_comb begin
      state_next  = state;
      inc_pulse   = 1'b0;
      repeat_fire = 1'b0;
      timeout_hit = (state != RUN) && ms_tick && !any_edge && !bus.btn_inc &&
                    (to_cnt == TO_W'(TIMEOUT_MS - 1));
      if (!bus.en)
         state_next = RUN;
      else if (mode_edge)
         state_next = next_mode(state);
      else if (timeout_hit)
         state_next = RUN;
      inc_pulse = bus.en && inc_edge && !mode_edge && (state != RUN);
`ifdef WATCH_SET_AUTOREPEAT_EN
      repeat_fire = bus.en && rep_active && bus.btn_inc && !mode_edge && ms_tick &&
                    (rep_cnt == rep_target);
`endif
      fire = inc_pulse || repeat_fire;
   end

   // Inactivity counter saturates at TIMEOUT_MS so it cannot wrap while idle in RUN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         to_cnt <= '0;
      else if (!bus.en || any_edge || bus.btn_inc)
         to_cnt <= '0;
      else if (ms_tick && to_cnt != TO_W'(TIMEOUT_MS))
         to_cnt <= to_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_q   <= 1'b0;
         blink_cnt <= '0;
      end else if (state_next == RUN) begin
         blink_q   <= 1'b0;
         blink_cnt <= '0;
      end else if (state_next != state) begin
         blink_q   <= 1'b1;
         blink_cnt <= '0;
      end else if (ms_tick) begin
         if (blink_cnt == BL_W'(BLINK_MS - 1)) begin
            blink_q   <= !blink_q;
            blink_cnt <= '0;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_sec_q  <= 1'b0;
         tick_min_q  <= 1'b0;
         tick_hour_q <= 1'b0;
         field_q     <= FIELD_NONE;
         setting_q   <= 1'b0;
      end else begin
         tick_sec_q  <= fire && (state == SET_SEC);
         tick_min_q  <= fire && (state == SET_MIN);
         tick_hour_q <= fire && (state == SET_HOUR);
         field_q     <= field_of(state_next);
         setting_q   <= (state_next != RUN);
      end
   end

   assign bus.tick_sec  = tick_sec_q;
   assign bus.tick_min  = tick_min_q;
   assign bus.tick_hour = tick_hour_q;
   assign bus.field     = field_q;
   assign bus.setting   = setting_q;
   assign bus.blink     = blink_q;

endmodule

// File: tb/tb_watch_set_fsm.sv
// Scoreboard bench for watch_set_fsm: stimulus queues expected ticks and
// state snapshots by cycle, a negedge monitor pops and compares them.
module tb_watch_set_fsm;

   typedef struct {
      int         cyc;
      logic [1:0] kind;
   } tick_exp_t;

   typedef struct {
      int         cyc;
      logic [1:0] fld;
      logic       set;
      logic       blk;
      logic       chk_blk;
   } state_exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   tick_exp_t  tick_q[$];
   state_exp_t state_q[$];

   watch_set_fsm_if bus();

   watch_set_fsm #(
      .CLK_HZ     (1000),
      .HOLD_MS    (5),
      .REPEAT_MS  (2),
      .TIMEOUT_MS (20),
      .BLINK_MS   (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic m, input logic i, input int n);
      bus.btn_mode = m;
      bus.btn_inc  = i;
      stepCycles(n);
   endtask

   task automatic expectTick(input int c, input logic [1:0] k);
      tick_exp_t t;
      t.cyc  = c;
      t.kind = k;
      tick_q.push_back(t);
   endtask

   task automatic expectState(input int c, input logic [1:0] f, input logic s, input logic b, input logic cb);
      state_exp_t e;
      e.cyc     = c;
      e.fld     = f;
      e.set     = s;
      e.blk     = b;
      e.chk_blk = cb;
      state_q.push_back(e);
   endtask

   // MODE press from a state that accepts it; f_after is the field one cycle later
   task automatic pressMode(input logic inc_lvl, input logic [1:0] f_after);
      expectState(cyc + 1, f_after, f_after != 2'd0, f_after != 2'd0, 1'b1);
      applyStimulus(1'b1, inc_lvl, 1);
      applyStimulus(1'b0, inc_lvl, 1);
   endtask

   always @(negedge clk) begin : monitor
      logic [1:0] kind;
      state_exp_t e;
      while (tick_q.size() > 0 && tick_q[0].cyc < cyc) begin
         checkOutput("tick_missing", 32'd0, {30'd0, tick_q[0].kind});
         void'(tick_q.pop_front());
      end
      if (bus.tick_sec || bus.tick_min || bus.tick_hour) begin
         checkOutput("tick_onehot", $countones({bus.tick_sec, bus.tick_min, bus.tick_hour}), 32'd1);
         kind = bus.tick_sec ? 2'd1 : (bus.tick_min ? 2'd2 : 2'd3);
         if (tick_q.size() == 0) begin
            checkOutput("tick_unexpected", {30'd0, kind}, 32'd0);
         end else begin
            checkOutput("tick_cycle", cyc, tick_q[0].cyc);
            checkOutput("tick_field", {30'd0, kind}, {30'd0, tick_q[0].kind});
            void'(tick_q.pop_front());
         end
      end
      while (state_q.size() > 0 && state_q[0].cyc <= cyc) begin
         e = state_q.pop_front();
         checkOutput("field", {30'd0, bus.field}, {30'd0, e.fld});
         checkOutput("setting", {31'd0, bus.setting}, {31'd0, e.set});
         if (e.chk_blk)
            checkOutput("blink", {31'd0, bus.blink}, {31'd0, e.blk});
      end
   end

   initial begin : stimulus
      int n;
      int m;
      bus.en       = 1'b1;
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      reset        = 1'b1;
      stepCycles(2);
      expectState(cyc, 2'd0, 1'b0, 1'b0, 1'b1);
      stepCycles(1);
      reset = 1'b0;
      stepCycles(2);
      expectState(cyc, 2'd0, 1'b0, 1'b0, 1'b1);
      stepCycles(1);

      $display("[TB] MODE cycle through all fields");
      pressMode(1'b0, 2'd3);
      pressMode(1'b0, 2'd2);
      pressMode(1'b0, 2'd1);
      pressMode(1'b0, 2'd0);

      $display("[TB] SET_MIN with INC held 10 cycles");
      pressMode(1'b0, 2'd3);
      pressMode(1'b0, 2'd2);
      n = cyc;
      expectTick(n + 1, 2'd2);
`ifdef WATCH_SET_AUTOREPEAT_EN
      expectTick(n + 6, 2'd2);
      expectTick(n + 8, 2'd2);
      expectTick(n + 10, 2'd2);
`endif
      applyStimulus(1'b0, 1'b1, 10);
      applyStimulus(1'b0, 1'b0, 2);
      expectState(cyc, 2'd2, 1'b1, 1'b0, 1'b0);
      stepCycles(1);

      $display("[TB] SET_HOUR with MODE and INC in the same cycle");
      pressMode(1'b0, 2'd1);
      pressMode(1'b0, 2'd0);
      pressMode(1'b0, 2'd3);
      n = cyc;
      expectState(n + 1, 2'd2, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1);
      applyStimulus(1'b0, 1'b1, 20);
      expectState(cyc, 2'd2, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1);

      $display("[TB] SET_SEC idle until timeout, blink phases");
      n = cyc;
      for (int k = 1; k <= 20; k++)
         expectState(n + k, 2'd1, 1'b1, (((k - 1) / 3) % 2) == 0, 1'b1);
      expectState(n + 21, 2'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 22);

      $display("[TB] en dropped while INC held in SET_SEC");
      pressMode(1'b0, 2'd3);
      pressMode(1'b0, 2'd2);
      pressMode(1'b0, 2'd1);
      n = cyc;
      expectTick(n + 1, 2'd1);
      applyStimulus(1'b0, 1'b1, 3);
      m = cyc;
      bus.en = 1'b0;
      expectState(m + 1, 2'd0, 1'b0, 1'b0, 1'b1);
      stepCycles(2);
      expectState(cyc + 1, 2'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1);
      applyStimulus(1'b0, 1'b1, 8);
      bus.en = 1'b1;
      applyStimulus(1'b0, 1'b0, 2);
      pressMode(1'b0, 2'd3);

      $display("[TB] SET_SEC with INC held 30 cycles");
      pressMode(1'b0, 2'd2);
      pressMode(1'b0, 2'd1);
      n = cyc;
      expectTick(n + 1, 2'd1);
`ifdef WATCH_SET_AUTOREPEAT_EN
      for (int t = n + 6; t <= n + 30; t += 2)
         expectTick(t, 2'd1);
`endif
      applyStimulus(1'b0, 1'b1, 30);
      expectState(cyc, 2'd1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1);

      $display("[TB] reset while a tick is high, buttons held through release");
      applyStimulus(1'b0, 1'b1, 1);
      reset = 1'b1;
      expectState(cyc, 2'd0, 1'b0, 1'b0, 1'b1);
      stepCycles(2);
      reset = 1'b0;
      stepCycles(3);
      expectState(cyc + 1, 2'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1);
      applyStimulus(1'b0, 1'b1, 2);
      applyStimulus(1'b0, 1'b0, 2);
      pressMode(1'b0, 2'd3);
      n = cyc;
      expectTick(n + 1, 2'd3);
      applyStimulus(1'b0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 4);

      while (tick_q.size() > 0) begin
         checkOutput("tick_never_seen", 32'd0, {30'd0, tick_q[0].kind});
         void'(tick_q.pop_front());
      end
      while (state_q.size() > 0) begin
         checkOutput("state_never_checked", cyc, state_q[0].cyc);
         void'(state_q.pop_front());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/watch_set_fsm.md
# watch_set_fsm

Time-setting sequencer for the digital watch. It turns two debounced push-buttons into single-cycle adjust pulses for the watch counter datapath: MODE selects which field (hour, minute, second) is being set, and INC increments it. It adds hold-to-repeat, an inactivity timeout and a display blink flag. It sits between the debouncers and the watch counter, in place of direct switch-selected ticking.

## Interface
- CLK_HZ, 100_000_000, clock frequency; must be a multiple of 1000
- HOLD_MS, 500, INC hold time before the first auto-repeat
- REPEAT_MS, 100, auto-repeat period
- TIMEOUT_MS, 10_000, inactivity time before returning to RUN
- BLINK_MS, 250, blink half-period
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- en  in  1  setting allowed (watch mode selected); low forces RUN
- btn_mode  in  1  debounced MODE level
- btn_inc  in  1  debounced INC level
- tick_sec  out  1  one-cycle +1 second pulse
- tick_min  out  1  one-cycle +1 minute pulse
- tick_hour  out  1  one-cycle +1 hour pulse
- field  out  2  0 none, 1 sec, 2 min, 3 hour
- setting  out  1  high in any SET state
- blink  out  1  display blanking phase; 0 in RUN

## Operation
- States: RUN, SET_HOUR, SET_MIN, SET_SEC. field and setting decode from the state.
- Edge detection uses a registered previous level for each button. An edge at cycle N means the input is high at N and the registered value is low.
- MODE edge: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN. MODE edges are ignored while en=0.
- INC edge in SET_x: one pulse on the matching tick_x. INC in RUN produces no pulse.
- Auto-repeat: while INC stays high in the same SET state, the first repeat pulse occurs HOLD_MS after the edge, then one pulse every REPEAT_MS. Releasing INC stops repeats at once.
- A MODE edge and an INC edge in the same cycle: MODE wins, the INC edge is discarded, and repeat is disarmed until the next INC edge.
- INC held across a MODE change: no repeat in the new state until a fresh INC edge.
- At most one tick output is high in any cycle.
- Timeout: an ms counter clears on any button edge and while INC is held. When it reaches TIMEOUT_MS in a SET state, the FSM goes to RUN.
- en low: the FSM goes to RUN on the next clock, the repeat and timeout counters clear, and no ticks are issued.
- blink: set to 1 on entry to any SET state, toggles every BLINK_MS ms, and is forced to 0 in RUN.
- Counter widths come from $clog2 of the maximum count. Counters saturate and never wrap.

## Timing
- Reset values: state RUN, all ticks 0, field 0, setting 0, blink 0, previous-level registers 0, all counters 0.
- All outputs are registered.
- An edge at cycle N produces its tick or state change at N+1.
- Millisecond prescaler: DIV = CLK_HZ/1000. It restarts on every button edge, so ms ticks fall at N+DIV, N+2·DIV, and so on.
- Repeat pulses occur at N+1+HOLD_MS·DIV, then every REPEAT_MS·DIV cycles.
- Timeout to RUN occurs at N+1+TIMEOUT_MS·DIV, with no other activity.
- Reset asserted mid-repeat: ticks drop to 0 asynchronously. After release, a button already held is not an edge until it is released and pressed again, because the previous-level register comes out of reset at 0 but edge detection is gated by an armed flag that is set only once both buttons are low.

## Configuration
- WATCH_SET_AUTOREPEAT_EN defined: hold-to-repeat as described.
- Undefined: exactly one tick per INC edge. The repeat counter is not built, HOLD_MS and REPEAT_MS are unused, and timeout and blink are unchanged.

## Structure
- Shared package watch_pkg: the state enum (RUN, SET_HOUR, SET_MIN, SET_SEC) and the field encodings FIELD_NONE/SEC/MIN/HOUR.
- One sub-module, ms_tick_gen: a divide-by-DIV prescaler with a synchronous restart input, producing a one-cycle ms_tick. It feeds the repeat, timeout and blink counters.

## Test plan
All scenarios use CLK_HZ=1000 (DIV=1), HOLD_MS=5, REPEAT_MS=2, TIMEOUT_MS=20, BLINK_MS=3, en=1.
- Reset released with both buttons low → all outputs 0, field=0. Three MODE presses → field goes 3, 2, 1, one cycle after each edge. A fourth press → field=0, setting=0.
- SET_MIN, INC edge at cycle N and held 10 cycles → tick_min at N+1, N+6, N+8, N+10. No tick_sec or tick_hour.
- SET_HOUR, MODE and INC rising in the same cycle → field=2 next cycle. No tick for 20 cycles while INC stays high.
- SET_SEC, no activity after the last edge at N → state RUN and blink=0 at N+21. blink toggles every 3 cycles before that.
- SET_SEC with INC held, en dropped at cycle M → setting=0 at M+1 and no further tick_sec.
- Build without WATCH_SET_AUTOREPEAT_EN, INC held 30 cycles in SET_SEC → exactly one tick_sec, and the FSM stays in SET_SEC because the timeout is suppressed while INC is held.
